// File: rtl/exception_ctrl_if.sv
// Signal bundle between the main control FSM (master) and the exception
// sequencer (slave): requests, PC/EPC values, vector memory port, write ports.
interface exception_ctrl_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_EXC = 3,
    parameter int CW      = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1
);
    logic [NUM_EXC-1:0] exc_req;
    logic               rte_req;
    logic [WIDTH-1:0]   pc;
    logic [WIDTH-1:0]   epc;
    logic [7:0]         mem_rdata;
    logic               busy;
    logic               done;
    logic [CW-1:0]      exc_code;
    logic [WIDTH-1:0]   mem_addr;
    logic               mem_rd;
    logic               epc_we;
    logic [WIDTH-1:0]   epc_wdata;
    logic               pc_we;
    logic [WIDTH-1:0]   pc_wdata;

    modport master (
        output exc_req, rte_req, pc, epc, mem_rdata,
        input  busy, done, exc_code, mem_addr, mem_rd,
               epc_we, epc_wdata, pc_we, pc_wdata
    );

    modport slave (
        input  exc_req, rte_req, pc, epc, mem_rdata,
        output busy, done, exc_code, mem_addr, mem_rd,
               epc_we, epc_wdata, pc_we, pc_wdata
    );
endinterface

// File: rtl/exception_ctrl.sv
// Exception entry / RTE sequencer: saves PC-4 into EPC, fetches the handler
// byte from the vector table after MEM_LAT cycles and loads it into PC.
module exception_ctrl #(
    parameter int WIDTH    = 32,
    parameter int NUM_EXC  = 3,
    parameter int MEM_LAT  = 3,
    parameter int VEC_BASE = 253,
    parameter int CW       = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1
) (
    input  logic              clk,
    input  logic              reset,
    exception_ctrl_if.slave   bus
);
    localparam int CNTW = $clog2(MEM_LAT + 1);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MEM_LAT - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    typedef enum logic [2:0] {IDLE, SAVE, WAIT, LOAD, RESTORE} state_t;

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [CW-1:0]    first_idx;
    logic             busy, done, mem_rd, epc_we, pc_we;
    logic [CW-1:0]    exc_code;
    logic [WIDTH-1:0] mem_addr, epc_wdata, pc_wdata;

    always_comb begin
        first_idx = '0;
        for (int unsigned i = NUM_EXC; i > 0; i--) begin
            if (bus.exc_req[i-1]) first_idx = CW'(i - 1);
        end
    end

    // Outputs are assigned for the state being entered, so each is a pure
    // register; mem_rdata is captured on the edge that enters LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            exc_code  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            epc_we    <= 1'b0;
            epc_wdata <= '0;
            pc_we     <= 1'b0;
            pc_wdata  <= '0;
        end else begin
            epc_we <= 1'b0;
            pc_we  <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|bus.exc_req) begin
                        state     <= SAVE;
                        exc_code  <= first_idx;
                        busy      <= 1'b1;
                        epc_we    <= 1'b1;
                        epc_wdata <= bus.pc - WIDTH'(4);
                        mem_rd    <= 1'b1;
                        mem_addr  <= WIDTH'(VEC_BASE) + WIDTH'(first_idx);
                    end else if (bus.rte_req) begin
                        state    <= RESTORE;
                        busy     <= 1'b1;
                        pc_we    <= 1'b1;
                        pc_wdata <= bus.epc;
                        done     <= 1'b1;
                    end
                end
                SAVE: begin
                    cnt <= CNT_LOAD;
                    if (MEM_LAT > 1) begin
                        state <= WAIT;
                    end else begin
                        state    <= LOAD;
                        pc_we    <= 1'b1;
                        pc_wdata <= WIDTH'(bus.mem_rdata);
                        done     <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state    <= LOAD;
                        pc_we    <= 1'b1;
                        pc_wdata <= WIDTH'(bus.mem_rdata);
                        done     <= 1'b1;
                    end
                end
                LOAD, RESTORE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    mem_rd <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.exc_code  = exc_code;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_rd    = mem_rd;
    assign bus.epc_we    = epc_we;
    assign bus.epc_wdata = epc_wdata;
    assign bus.pc_we     = pc_we;
    assign bus.pc_wdata  = pc_wdata;
endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: two instances (MEM_LAT=3 and MEM_LAT=1) share the
// same stimulus and are compared every cycle against a transaction-level model.
module tb_exception_ctrl;
    localparam int VEC = 253;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  exc_req = '0;
    logic        rte_req = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] epc = '0;
    logic [7:0]  mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exception_ctrl_if #(.WIDTH(32), .NUM_EXC(3)) ia ();
    exception_ctrl_if #(.WIDTH(32), .NUM_EXC(3)) ib ();

    assign ia.exc_req   = exc_req;
    assign ia.rte_req   = rte_req;
    assign ia.pc        = pc;
    assign ia.epc       = epc;
    assign ia.mem_rdata = mem[ia.mem_addr[7:0]];
    assign ib.exc_req   = exc_req;
    assign ib.rte_req   = rte_req;
    assign ib.pc        = pc;
    assign ib.epc       = epc;
    assign ib.mem_rdata = mem[ib.mem_addr[7:0]];

    exception_ctrl #(.WIDTH(32), .NUM_EXC(3), .MEM_LAT(3), .VEC_BASE(VEC)) u_a (
        .clk(clk), .reset(reset), .bus(ia));
    exception_ctrl #(.WIDTH(32), .NUM_EXC(3), .MEM_LAT(1), .VEC_BASE(VEC)) u_b (
        .clk(clk), .reset(reset), .bus(ib));

    // Model: kind 0 = idle, 1 = exception entry, 2 = return; k = cycle number
    // within the sequence (1 = first cycle after acceptance).
    int          lat    [2] = '{3, 1};
    int          m_kind [2];
    int          m_k    [2];
    int          m_code [2];
    bit          m_clean[2];
    logic [31:0] m_epcw [2];
    logic [31:0] m_pcw  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [2:0] r);
        logic [2:0] b;
        b = r & (~r + 3'd1);
        return $clog2(b);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_kind[d] = 0; m_k[d] = 0; m_code[d] = 0; m_clean[d] = 1'b1;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_kind[d] = 0; m_k[d] = 0; m_code[d] = 0; m_clean[d] = 1'b1;
            end else if (m_kind[d] == 0) begin
                if (exc_req != 0) begin
                    m_kind[d] = 1; m_k[d] = 1; m_code[d] = lowest(exc_req);
                    m_epcw[d] = pc - 32'd4; m_clean[d] = 1'b0;
                end else if (rte_req) begin
                    m_kind[d] = 2; m_k[d] = 1; m_pcw[d] = epc; m_clean[d] = 1'b0;
                end
            end else if ((m_kind[d] == 1 && m_k[d] == lat[d] + 1) || m_kind[d] == 2) begin
                m_kind[d] = 0; m_k[d] = 0;
            end else begin
                m_k[d]++;
            end
        end
    endtask

    task automatic check_unit(input int d, input logic busy, input logic done,
                              input logic [1:0] code, input logic [31:0] addr,
                              input logic rd, input logic ewe, input logic [31:0] ewd,
                              input logic pwe, input logic [31:0] pwd);
        string p;
        logic  e_done;
        p = (d == 0) ? "A" : "B";
        e_done = (m_kind[d] == 1 && m_k[d] == lat[d] + 1) || m_kind[d] == 2;
        check({p, ".busy"},     32'(busy), 32'(m_kind[d] != 0));
        check({p, ".done"},     32'(done), 32'(e_done));
        check({p, ".pc_we"},    32'(pwe),  32'(e_done));
        check({p, ".mem_rd"},   32'(rd),   32'(m_kind[d] == 1));
        check({p, ".epc_we"},   32'(ewe),  32'(m_kind[d] == 1 && m_k[d] == 1));
        check({p, ".exc_code"}, 32'(code), 32'(m_code[d]));
        if (m_kind[d] == 1) check({p, ".mem_addr"}, addr, 32'(VEC + m_code[d]));
        if (m_kind[d] == 1 && m_k[d] == 1) check({p, ".epc_wdata"}, ewd, m_epcw[d]);
        if (e_done) check({p, ".pc_wdata"}, pwd,
                          (m_kind[d] == 1) ? 32'(mem[VEC + m_code[d]]) : m_pcw[d]);
        if (m_clean[d]) begin
            check({p, ".addr_rst"}, addr, 32'd0);
            check({p, ".epcw_rst"}, ewd,  32'd0);
            check({p, ".pcw_rst"},  pwd,  32'd0);
        end
    endtask

    task automatic compare_all();
        check_unit(0, ia.busy, ia.done, ia.exc_code, ia.mem_addr, ia.mem_rd,
                   ia.epc_we, ia.epc_wdata, ia.pc_we, ia.pc_wdata);
        check_unit(1, ib.busy, ib.done, ib.exc_code, ib.mem_addr, ib.mem_rd,
                   ib.epc_we, ib.epc_wdata, ib.pc_we, ib.pc_wdata);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        exc_req = '0; rte_req = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[253] = 8'h3C; mem[254] = 8'h8C; mem[255] = 8'hF1;
        model_reset();
        #1 compare_all();
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b0;
        idle_cycles(2);

        // overflow entry, pc=0x104
        exc_req = 3'b010; pc = 32'h104;
        cycle();
        check("ovf_epcw", ia.epc_wdata, 32'h100);
        exc_req = '0;
        for (int i = 0; i < 3; i++) cycle();
        check("ovf_pcw", ia.pc_wdata, 32'h8C);
        check("ovf_done", 32'(ia.done), 32'd1);
        idle_cycles(2);

        // priority
        exc_req = 3'b110; cycle();
        check("prio110", 32'(ia.exc_code), 32'd1);
        idle_cycles(5);
        exc_req = 3'b111; cycle();
        check("prio111", ia.mem_addr, 32'd253);
        idle_cycles(5);

        // RTE
        rte_req = 1'b1; epc = 32'h2000; cycle();
        check("rte_pcw", ia.pc_wdata, 32'h2000);
        idle_cycles(2);

        // collision, then an ignored pulse while busy
        rte_req = 1'b1; exc_req = 3'b001; cycle();
        rte_req = 1'b0; exc_req = '0; cycle();
        exc_req = 3'b100; cycle();
        exc_req = '0;
        idle_cycles(4);

        // reset mid-WAIT, then a fresh code-2 entry
        exc_req = 3'b010; cycle();
        exc_req = '0; cycle();
        #2 reset = 1'b1;
        #1 model_reset();
        compare_all();
        cycle();
        reset = 1'b0;
        exc_req = 3'b100; cycle();
        exc_req = '0;
        idle_cycles(5);

        // wrap and minimum latency
        exc_req = 3'b001; pc = 32'h0; cycle();
        check("wrap_epcw", ib.epc_wdata, 32'hFFFF_FFFC);
        exc_req = '0; cycle();
        check("minlat_done", 32'(ib.done), 32'd1);
        idle_cycles(5);

        // randomized traffic; requests are occasionally held across done
        for (int i = 0; i < 600; i++) begin
            exc_req = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            rte_req = ($urandom_range(0, 4) == 0);
            pc      = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom & 32'hFFFF_FFFC);
            epc     = $urandom;
            cycle();
        end
        idle_cycles(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Parametrised exception-entry and return sequencer for the multicycle MIPS datapath, sitting beside the main control FSM. When the control FSM raises an exception request (invalid opcode, overflow, divide-by-zero, or more via `NUM_EXC`), this block does three things:
- saves the faulting PC into EPC;
- reads the handler byte from the vector table in memory, waiting a configurable number of cycles for memory latency;
- loads that byte into PC.

It also performs the RTE return (PC ← EPC). The main FSM stalls on `busy` and resumes at fetch on `done`.

## Interface
Parameters:
- `WIDTH`, 32, datapath/PC/address width.
- `NUM_EXC`, 3, number of exception sources; bit 0 has highest priority.
- `MEM_LAT`, 3, memory read latency in cycles; legal range ≥1.
- `VEC_BASE`, 253, address of vector byte for code 0; code n reads `VEC_BASE+n`.
- `CW`, max(1,$clog2(NUM_EXC)), width of `exc_code`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `exc_req` in `NUM_EXC`: exception requests, level, sampled only in IDLE.
- `rte_req` in 1: return-from-exception request, sampled only in IDLE.
- `pc` in `WIDTH`: current PC, already advanced by 4 in fetch.
- `epc` in `WIDTH`: current EPC register contents.
- `mem_rdata` in 8: byte returned by memory.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse on the final cycle of a sequence.
- `exc_code` out `CW`: latched code of the exception being serviced.
- `mem_addr` out `WIDTH`: vector read address.
- `mem_rd` out 1: memory read enable.
- `epc_we` out 1; `epc_wdata` out `WIDTH`: EPC write port.
- `pc_we` out 1; `pc_wdata` out `WIDTH`: PC write port.

## Operation
- Moore FSM with states IDLE, SAVE, WAIT, LOAD, RESTORE, a latched code register, and a latency counter of width `$clog2(MEM_LAT+1)`.
- **IDLE**:
  - If any `exc_req` bit is set, latch the lowest set index into `exc_code` and go to SAVE.
  - Else if `rte_req` is set, go to RESTORE.
  - Else stay in IDLE.
  - Exception requests take priority over `rte_req` when both are set.
- **SAVE**:
  - `epc_we`=1, `epc_wdata`=`pc`−4, modulo 2^WIDTH (pc=0 → all-ones minus 3).
  - `mem_rd`=1, `mem_addr`=`VEC_BASE`+`exc_code`, zero-extended.
  - Counter loads `MEM_LAT`−1.
  - Go to WAIT if `MEM_LAT`>1, else go to LOAD.
- **WAIT**:
  - `mem_rd`=1, `mem_addr` held; counter decrements.
  - Go to LOAD when the counter reaches 1 → 0.
- **LOAD**:
  - `mem_addr` held, `mem_rd`=1.
  - `pc_we`=1, `pc_wdata`={`WIDTH`−8 zeros, `mem_rdata`}.
  - `done`=1; go to IDLE.
- **RESTORE**:
  - `pc_we`=1, `pc_wdata`=`epc`, `done`=1; go to IDLE.
  - EPC is not modified.
- Requests arriving while `busy` are ignored; there is no queueing and no nesting. The requester holds the request until it sees `done`.
- `exc_code` holds its value until the next exception is accepted. RTE does not change it.
- All write enables are single-cycle, and every output is a function of the registered state only.

## Timing
- **Reset**: all outputs are 0 and the state is IDLE, immediately and asynchronously. This includes `exc_code`, `mem_addr`, `pc_wdata` and `epc_wdata`.
- **Reset mid-sequence**: the sequence is abandoned. An EPC write already performed in SAVE stands. No PC write occurs.
- **Exception latency**, with a request seen at edge 0 in IDLE:
  - SAVE occupies cycle 1.
  - WAIT occupies cycles 2..`MEM_LAT`.
  - LOAD/`done` occurs in cycle `MEM_LAT`+1.
  - `mem_addr` is therefore stable for `MEM_LAT` cycles before `mem_rdata` is sampled.
- **RTE latency**: RESTORE/`done` occurs in cycle 1.
- **Back-to-back sequences**: IDLE must be re-entered for at least one cycle between sequences. A request held through `done` is accepted on the following edge.

## Test plan
- **Overflow entry**: `MEM_LAT`=3, `exc_req`=3'b010, `pc`=0x104, memory[254]=0x8C.
  - Cycle 1: `epc_we`=1, `epc_wdata`=0x100.
  - Cycles 1–4: `mem_addr`=254.
  - Cycle 4: `pc_we`=1, `pc_wdata`=0x0000008C, `done`=1.
- **Priority**: `exc_req`=3'b110 → `exc_code`=1, `mem_addr`=254. Repeat with 3'b111 → `exc_code`=0, `mem_addr`=253.
- **RTE**: `rte_req`=1, `epc`=0x2000 → next cycle `pc_we`=1, `pc_wdata`=0x2000, `done`=1, `epc_we`=0.
- **Collision**: `rte_req`=1 together with `exc_req`=3'b001 → exception path to `mem_addr`=253 is taken and no RESTORE occurs. A new `exc_req` pulse while `busy` is ignored.
- **Reset**: assert `reset` mid-WAIT → all outputs 0 in the same cycle and state IDLE. After release, a fresh `exc_req`=3'b100 completes normally at `mem_addr`=255.
- **Wrap and minimum latency**: `MEM_LAT`=1, `pc`=0 → `epc_wdata`=0xFFFFFFFC in cycle 1 and LOAD/`done` in cycle 2 (no WAIT state).
